// File: rtl/hypercpu_alu_arbiter.sv
// rtl/hypercpu_alu_arbiter.sv - round-robin sequencer sharing one ALU between two requesters
//
// Purpose: arbitrates the execute stage (requester 0) and the address/aux
// unit (requester 1) onto a single combinational ALU. The granted operands
// and opcode are registered into the ALU and held for a per-opcode latency.
// The result is then returned to the granted requester as a one-cycle pulse.
//
// Parameters:
//   MULDIV_CYCLES  hold cycles for mul/div opcodes 4'he/4'hf (legal 1..15)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (0, 1)
//   reqN_op, reqN_a, reqN_b    opcode and operands for requester N
//   rspN_valid, rspN_r         one-cycle result pulse and held result
//   alu_a, alu_b, alu_op       registered ALU inputs
//   alu_r                      ALU result, combinational from alu_*
module hypercpu_alu_arbiter #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_r,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_r,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_r
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  // Counter preload for mul/div: the capture edge is L edges after accept,
  // so the counter starts at L-1 and completes when it reaches zero.
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  logic [0:0]  state;
  logic        prio;
  logic        owner;
  logic [3:0]  cnt;

  logic        any_valid;
  logic        grant;
  logic        accept;
  logic [3:0]  acc_op;
  logic [31:0] acc_a;
  logic [31:0] acc_b;
  logic        is_muldiv;

  always_comb begin
    any_valid = req0_valid | req1_valid;
    // With both valid the pointer decides; otherwise the lone valid wins.
    grant     = (req0_valid && req1_valid) ? prio : req1_valid;
    // Gated by rst_n so ready reads 0 for the whole reset interval.
    req0_ready = rst_n && (state == ST_IDLE) && any_valid && !grant;
    req1_ready = rst_n && (state == ST_IDLE) && any_valid && grant;
    accept     = req0_ready | req1_ready;
    acc_op     = grant ? req1_op : req0_op;
    acc_a      = grant ? req1_a  : req0_a;
    acc_b      = grant ? req1_b  : req0_b;
    is_muldiv  = (acc_op == 4'he) || (acc_op == 4'hf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_op     <= 4'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_r     <= 32'd0;
      rsp1_r     <= 32'd0;
    end else begin
      // Response pulses last exactly one cycle.
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          alu_a  <= acc_a;
          alu_b  <= acc_b;
          alu_op <= acc_op;
          owner  <= grant;
          cnt    <= is_muldiv ? MD_LOAD : 4'd0;
          state  <= ST_EXEC;
        end
      end else begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          if (owner) begin
            rsp1_r     <= alu_r;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_r     <= alu_r;
            rsp0_valid <= 1'b1;
          end
          // Pointer moves only on completion, to the requester not served.
          prio  <= ~owner;
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_hypercpu_alu_arbiter.sv
// tb/tb_hypercpu_alu_arbiter.sv - directed self-checking bench for hypercpu_alu_arbiter
module tb_hypercpu_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp0_valid;
  logic [31:0] rsp0_r;
  logic        rsp1_valid;
  logic [31:0] rsp1_r;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_r;

  int passed;
  int total;

  hypercpu_alu_arbiter #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_r(rsp0_r),
    .rsp1_valid(rsp1_valid), .rsp1_r(rsp1_r),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r)
  );

  // Stand-in ALU covering the opcodes exercised here.
  always_comb begin
    alu_r = 32'd0;
    case (alu_op)
      4'h3: alu_r = alu_a | alu_b;
      4'h6: alu_r = {31'd0, alu_a == alu_b};
      4'hc: alu_r = alu_a + alu_b;
      4'hd: alu_r = alu_a - alu_b;
      4'he: alu_r = alu_a * alu_b;
      4'hf: alu_r = (alu_b == 32'd0) ? 32'hffff_ffff : alu_a / alu_b;
      default: alu_r = 32'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Reset state, with a request pending to show ready is held low.
    req0_valid = 1'b1; req0_op = 4'hc; req0_a = 32'd5; req0_b = 32'd7;
    tick(); tick();
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_r", rsp0_r, 32'd0);
    chk("rst_rsp1_r", rsp1_r, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);

    // Single add: 5 + 7.
    rst_n = 1'b1;
    #1;
    chk("add_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_alu_op", {28'd0, alu_op}, 32'hc);
    chk("add_busy_ready", {31'd0, req0_ready}, 32'd0);
    chk("add_no_early_rsp", {31'd0, rsp0_valid}, 32'd0);
    tick();
    chk("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_rsp0_r", rsp0_r, 32'd12);
    chk("add_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    tick();
    chk("add_pulse_end", {31'd0, rsp0_valid}, 32'd0);

    // Contention: grants must alternate 0,1,0,1 starting from reset pointer.
    do_reset();
    req0_valid = 1'b1; req0_op = 4'h3; req0_a = 32'hf0; req0_b = 32'h0f;
    req1_valid = 1'b1; req1_op = 4'hd; req1_a = 32'd10; req1_b = 32'd3;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        chk($sformatf("cont%0d_req0_ready", i), {31'd0, req0_ready}, 32'd1);
        chk($sformatf("cont%0d_req1_ready", i), {31'd0, req1_ready}, 32'd0);
      end else begin
        chk($sformatf("cont%0d_req0_ready", i), {31'd0, req0_ready}, 32'd0);
        chk($sformatf("cont%0d_req1_ready", i), {31'd0, req1_ready}, 32'd1);
      end
      tick();
      tick();
      if (i % 2 == 0) begin
        chk($sformatf("cont%0d_rsp0_valid", i), {31'd0, rsp0_valid}, 32'd1);
        chk($sformatf("cont%0d_rsp0_r", i), rsp0_r, 32'hff);
        chk($sformatf("cont%0d_rsp1_valid", i), {31'd0, rsp1_valid}, 32'd0);
      end else begin
        chk($sformatf("cont%0d_rsp1_valid", i), {31'd0, rsp1_valid}, 32'd1);
        chk($sformatf("cont%0d_rsp1_r", i), rsp1_r, 32'd7);
        chk($sformatf("cont%0d_rsp0_valid", i), {31'd0, rsp0_valid}, 32'd0);
      end
    end

    // Divide 100 / 7 with a four-cycle hold; req0 waits through EXEC.
    do_reset();
    req1_valid = 1'b1; req1_op = 4'hf; req1_a = 32'd100; req1_b = 32'd7;
    #1;
    chk("div_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'hc; req0_a = 32'd1; req0_b = 32'd2;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("div_hold%0d_alu_a", k), alu_a, 32'd100);
      chk($sformatf("div_hold%0d_alu_b", k), alu_b, 32'd7);
      chk($sformatf("div_hold%0d_alu_op", k), {28'd0, alu_op}, 32'hf);
      chk($sformatf("div_hold%0d_rsp1_valid", k), {31'd0, rsp1_valid}, 32'd0);
      chk($sformatf("div_hold%0d_req0_ready", k), {31'd0, req0_ready}, 32'd0);
      if (k < 3) tick();
    end
    tick();
    chk("div_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("div_rsp1_r", rsp1_r, 32'd14);
    chk("div_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("div_follow_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("div_follow_rsp0_r", rsp0_r, 32'd3);
    chk("div_follow_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("div_follow_rsp1_r_kept", rsp1_r, 32'd14);

    // Unused opcode 4'ha passes through; ALU returns 0.
    req0_valid = 1'b1; req0_op = 4'ha; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    chk("unused_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("unused_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("unused_rsp0_r", rsp0_r, 32'd0);

    // Reset two cycles into a multiply: nothing may be returned.
    req0_valid = 1'b1; req0_op = 4'he; req0_a = 32'd3; req0_b = 32'd4;
    #1;
    chk("mul_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_alu_a", alu_a, 32'd0);
    chk("mrst_alu_b", alu_b, 32'd0);
    chk("mrst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("mrst_rsp0_r", rsp0_r, 32'd0);
    chk("mrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mrst_quiet%0d", k), {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    end
    // Pointer back at 0: with both valid, req0 wins.
    req0_valid = 1'b1; req0_op = 4'hc; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b1; req1_op = 4'h6; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    chk("mrst_prio_req0", {31'd0, req0_ready}, 32'd1);
    chk("mrst_prio_req1", {31'd0, req1_ready}, 32'd0);

    // Pointer update: req1 alone served, then req0 wins the next contention.
    req0_valid = 1'b0;
    #1;
    chk("ptr_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("ptr_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("ptr_rsp1_r", rsp1_r, 32'd1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("ptr_both_req0", {31'd0, req0_ready}, 32'd1);
    chk("ptr_both_req1", {31'd0, req1_ready}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hypercpu_alu_arbiter.md
# hypercpu_alu_arbiter

Sequencing controller that shares the single 32-bit `hypercpu_alu` datapath between two requesters: requester 0 is the execute stage, requester 1 is the address/auxiliary unit. It arbitrates round-robin, registers the granted operands and opcode into the ALU, and holds them for a per-opcode latency. Multiply and divide (`op` 4'he/4'hf) are allowed multiple cycles to settle. It then captures the ALU result and returns it to the granted requester as a one-cycle response pulse.

## Interface
- `MULDIV_CYCLES`, default 4: hold cycles for op 4'he/4'hf; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_op`  in  4  ALU opcode.
- `req0_a`, `req0_b`  in  32  operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0.
- `rsp0_valid`  out  1  one-cycle result pulse to requester 0.
- `rsp0_r`  out  32  result for requester 0; holds its last value.
- `rsp1_valid`, `rsp1_r`: same as requester 0.
- `alu_a`, `alu_b`  out  32  registered operands to the ALU.
- `alu_op`  out  4  registered opcode to the ALU.
- `alu_r`  in  32  ALU result, combinational from `alu_*`.

## Operation
- **States.**
  - IDLE: ready for a new request.
  - EXEC: holding the ALU inputs while an operation settles.
- **Round-robin pointer `prio`.** Reset value 0.
  - Grant: if both valid, grant = `prio`; if one valid, grant = that one; if none, no grant.
- **Ready.** `reqN_ready` = (state == IDLE) && grant == N.
  - Combinational from state, `prio` and the valids only.
  - A requester's valid must not depend on its ready.
- **IDLE, on a handshake** (`reqN_valid && reqN_ready`) at a clock edge:
  - load `alu_a`/`alu_b`/`alu_op` from requester N;
  - record owner = N;
  - load the counter with L−1, where L = `MULDIV_CYCLES` for op 4'he/4'hf and L = 1 for all other ops, including the unused 4'ha/4'hb (the ALU returns 0 for these; they are passed through);
  - go to EXEC.
- **EXEC.**
  - Counter ≠ 0: decrement; `alu_*` held stable.
  - Counter == 0, at that edge:
    - `rspOwner_r` ← `alu_r`;
    - `rspOwner_valid` ← 1 for exactly one cycle;
    - `prio` ← the requester not served;
    - go to IDLE.
- **Responses.**
  - No backpressure; the requester must consume the pulse.
  - `rsp0_valid` and `rsp1_valid` are never both high.
  - The non-owner `rsp_r` is unchanged.
- **Arithmetic.** Full 32-bit, performed by the ALU. Width truncation and divide-by-zero results are whatever `alu_r` presents; the block adds no checks.
- **Reset values** (all outputs 0, any time `rst_n` is low):
  - state = IDLE, `prio` = 0, counter = 0;
  - `alu_a` = `alu_b` = 0, `alu_op` = 0;
  - `rsp*_r` = 0, `rsp*_valid` = 0, `req*_ready` = 0 while in reset.
- **Reset mid-EXEC:** the in-flight operation is discarded and no response is issued.

## Timing
- **Accept → response.** Handshake at edge E:
  - `alu_*` valid after E;
  - result captured at edge E+L;
  - `rspN_valid` high for the cycle between E+L and E+L+1.
- **Latency.** L cycles from accept to response: 1 for normal ops, `MULDIV_CYCLES` for mul/div.
- **Next accept.** IDLE is re-entered at E+L, so ready can assert in the same cycle as the response pulse; the next accept is at the earliest at edge E+L+1.
- **Throughput.** One operation per L+1 cycles.
- **Held inputs.** Requests held valid while not ready keep their operands; the block samples operands only at the handshake edge.
- **Priority only on completion.** Valid changes during EXEC do not affect `prio`.

## Test plan
- **Single add.** Reset, then req0 valid, op 4'hc, a=5, b=7.
  - Required: req0_ready=1 in the first cycle after reset.
  - Required: rsp0_valid pulses 1 cycle after accept with rsp0_r=12.
  - Required: rsp1_valid stays 0.
- **Contention.** Both requesters valid continuously; req0 op 4'h3 a=F0 b=0F, req1 op 4'hd a=10 b=3.
  - Required grants: 0,1,0,1.
  - Required: responses FF and 7 alternate, one every 2 cycles.
- **Divide with `MULDIV_CYCLES`=4.** req1 op 4'hf a=100 b=7.
  - Required: rsp1_valid exactly 4 cycles after accept, rsp1_r=14.
  - Required: `alu_*` stable through EXEC.
  - Required: req0, valid during EXEC, gets ready only in the response cycle.
- **Unused op.** req0 op 4'ha a=1 b=1.
  - Required: rsp0_r=0 after 1 cycle.
- **Reset mid-multiply.** Multiply a=3 b=4 with `MULDIV_CYCLES`=4; drop `rst_n` 2 cycles after accept.
  - Required: no rsp pulse; all outputs 0; `prio`=0.
  - Required: the next req1-only request is granted.
- **Pointer update.** req1 alone is served (op 4'h6 a=9 b=9 → rsp1_r=1); then both requesters valid.
  - Required: req0 granted first.
